// File: rtl/triangle_fetch_unit.sv
// triangle_fetch_unit: burst-reads one triangle (TRI_WORDS words) from the scene BRAM,
// assembles the words into a flat vector and returns it with a one-cycle tri_ready strobe.
// One request in flight at a time; the BRAM read latency is fixed by RD_LAT.
// Optional single-entry result cache is built when TRI_FETCH_CACHE_EN is defined;
// without it the flush input has no effect.
module triangle_fetch_unit #(
  parameter int WORD_W     = 32,
  parameter int TRI_WORDS  = 9,
  parameter int ADDR_W     = 12,
  parameter int MEM_ADDR_W = 16,
  parameter int MAX_TRIS   = 1024,
  parameter int RD_LAT     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  input  logic [ADDR_W-1:0]           req_addr,
  output logic                        req_ready,
  output logic                        mem_en,
  output logic [MEM_ADDR_W-1:0]       mem_addr,
  input  logic [WORD_W-1:0]           mem_rdata,
  output logic                        tri_ready,
  output logic                        tri_err,
  output logic [TRI_WORDS*WORD_W-1:0] tri_data,
  input  logic                        flush
);

  localparam int K_W    = (TRI_WORDS > 1) ? $clog2(TRI_WORDS) : 1;
  localparam int DATA_W = TRI_WORDS * WORD_W;
  localparam logic [K_W-1:0] K_LAST = K_W'(TRI_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // FSM state and registered outputs
  state_t                  state_q, state_d;
  logic                    req_ready_q, req_ready_d;
  logic                    mem_en_q, mem_en_d;
  logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic                    tri_ready_q, tri_ready_d;
  logic                    tri_err_q, tri_err_d;
  logic [DATA_W-1:0]       tri_data_q, tri_data_d;

  // Read-tag pipeline: one {valid, k} tag per outstanding BRAM read
  logic [RD_LAT-1:0]          pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0][K_W-1:0] pipe_k_q, pipe_k_d;

  // Staging register collecting returned words until the burst is complete
  logic [DATA_W-1:0] staging_q, staging_d;

  logic                  accept;
  logic                  in_range;
  logic                  hit;
  logic                  fill;
  logic                  older_busy;
  logic                  exit_vld;
  logic [K_W-1:0]        exit_k;
  logic [MEM_ADDR_W-1:0] base_addr;

  assign req_ready = req_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_addr  = mem_addr_q;
  assign tri_ready = tri_ready_q;
  assign tri_err   = tri_err_q;
  assign tri_data  = tri_data_q;

  assign accept    = req_valid & req_ready_q;
  assign in_range  = (32'(req_addr) < 32'(MAX_TRIS));
  assign base_addr = MEM_ADDR_W'(req_addr) * MEM_ADDR_W'(TRI_WORDS);

  // The tag leaving the last pipeline stage lines up with mem_rdata
  assign exit_vld = pipe_vld_q[RD_LAT-1];
  assign exit_k   = pipe_k_q[RD_LAT-1];

  genvar gi;

  // Tag pipeline next-state: stage 0 captures the read issued this cycle
  generate
    for (gi = 0; gi < RD_LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign pipe_vld_d[gi] = mem_en_q;
        assign pipe_k_d[gi]   = k_q;
      end else begin : g_body
        assign pipe_vld_d[gi] = pipe_vld_q[gi-1];
        assign pipe_k_d[gi]   = pipe_k_q[gi-1];
      end
    end
  endgenerate

  // Staging next-state: a returning word lands in the slot named by its tag
  generate
    for (gi = 0; gi < TRI_WORDS; gi++) begin : g_stage
      assign staging_d[gi*WORD_W +: WORD_W] =
        (exit_vld && (exit_k == K_W'(gi))) ? mem_rdata : staging_q[gi*WORD_W +: WORD_W];
    end
  endgenerate

  // Any read still in flight other than the one returning this cycle
  always_comb begin
    older_busy = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      older_busy = older_busy | pipe_vld_q[i];
    end
  end

`ifdef TRI_FETCH_CACHE_EN
  logic              cache_valid_q, cache_valid_d;
  logic [ADDR_W-1:0] cache_idx_q, cache_idx_d;

  // A flush on the accept edge forces a miss even for a matching index
  assign hit = cache_valid_q & (req_addr == cache_idx_q) & ~flush;

  // Cache entry update: flush beats a simultaneous fill
  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_idx_d   = cache_idx_q;
    if (fill) begin
      cache_valid_d = 1'b1;
      cache_idx_d   = idx_q;
    end
    if (flush) begin
      cache_valid_d = 1'b0;
    end
  end

  // Cache entry registers; tri_data itself holds the cached triangle
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid_q <= 1'b0;
      cache_idx_q   <= '0;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_idx_q   <= cache_idx_d;
    end
  end
`else
  logic unused_ok;

  assign hit       = 1'b0;
  assign unused_ok = flush ^ fill ^ (^idx_q);
`endif

  // FSM next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    mem_en_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    k_d         = k_q;
    idx_d       = idx_q;
    tri_ready_d = 1'b0;
    tri_err_d   = 1'b0;
    tri_data_d  = tri_data_q;
    fill        = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        if (accept) begin
          idx_d = req_addr;
          if (!in_range) begin
            // Out of range: report immediately, leave tri_data alone
            state_d     = S_DONE;
            tri_ready_d = 1'b1;
            tri_err_d   = 1'b1;
          end else if (hit) begin
            // Cached: tri_data already holds this triangle
            state_d     = S_DONE;
            tri_ready_d = 1'b1;
          end else begin
            state_d     = S_ISSUE;
            req_ready_d = 1'b0;
            mem_en_d    = 1'b1;
            mem_addr_d  = base_addr;
            k_d         = '0;
          end
        end
      end

      S_ISSUE: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
        end else begin
          mem_en_d   = 1'b1;
          mem_addr_d = mem_addr_q + MEM_ADDR_W'(1);
          k_d        = k_q + K_W'(1);
        end
      end

      S_DRAIN: begin
        // The last outstanding word returns this cycle; publish including it
        if (!older_busy) begin
          state_d     = S_DONE;
          req_ready_d = 1'b1;
          tri_ready_d = 1'b1;
          tri_data_d  = staging_d;
          fill        = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      k_q         <= '0;
      idx_q       <= '0;
      tri_ready_q <= 1'b0;
      tri_err_q   <= 1'b0;
      tri_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      k_q         <= k_d;
      idx_q       <= idx_d;
      tri_ready_q <= tri_ready_d;
      tri_err_q   <= tri_err_d;
      tri_data_q  <= tri_data_d;
    end
  end

  // Tag pipeline; reset drops every tag so late BRAM data is ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q <= '0;
      pipe_k_q   <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      pipe_k_q   <= pipe_k_d;
    end
  end

  // Staging register for words of the burst in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      staging_q <= '0;
    end else begin
      staging_q <= staging_d;
    end
  end

endmodule

// File: tb/tb_triangle_fetch_unit.sv
// Directed, table-driven bench for triangle_fetch_unit with a RD_LAT=2 BRAM model
// where word[a] = a.
module tb_triangle_fetch_unit;

  localparam int WORD_W     = 32;
  localparam int TRI_WORDS  = 9;
  localparam int ADDR_W     = 12;
  localparam int MEM_ADDR_W = 16;
  localparam int MAX_TRIS   = 1024;
  localparam int RD_LAT     = 2;
  localparam int DW         = TRI_WORDS * WORD_W;
  localparam int NV         = 14;

`ifdef TRI_FETCH_CACHE_EN
  localparam int HIT_LAT = 1;
  localparam int HIT_NRD = 0;
`else
  localparam int HIT_LAT = 12;
  localparam int HIT_NRD = 9;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  req_valid = 1'b0;
  logic [ADDR_W-1:0]     req_addr = '0;
  logic                  req_ready;
  logic                  mem_en;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0]     mem_rdata;
  logic                  tri_ready;
  logic                  tri_err;
  logic [DW-1:0]         tri_data;
  logic                  flush = 1'b0;

  triangle_fetch_unit #(
    .WORD_W(WORD_W), .TRI_WORDS(TRI_WORDS), .ADDR_W(ADDR_W),
    .MEM_ADDR_W(MEM_ADDR_W), .MAX_TRIS(MAX_TRIS), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .tri_ready(tri_ready), .tri_err(tri_err),
    .tri_data(tri_data), .flush(flush)
  );

  always #5 clk = ~clk;

  // BRAM model, two-cycle read latency, word[a] = a
  logic [WORD_W-1:0] rd_s1, rd_s2;
  always @(posedge clk) begin
    rd_s1 <= mem_en ? 32'(mem_addr) : 32'hBAD0_0000;
    rd_s2 <= rd_s1;
  end
  assign mem_rdata = rd_s2;

  // Read monitor: record every address presented with mem_en and its cycle
  int cyc = 0;
  int rd_addr_q[$];
  int rd_cyc_q[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en) begin
      rd_addr_q.push_back(int'(mem_addr));
      rd_cyc_q.push_back(cyc);
    end
  end

  typedef struct {
    logic [ADDR_W-1:0] idx;
    bit                b2b;
    bit                flush_first;
    bit                flush_with;
    bit                flush_during;
    int                exp_lat;
    bit                exp_err;
    int                exp_nrd;
    int                exp_base;
  } vec_t;

  vec_t          vecs[NV];
  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] last_good = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_fetch(input vec_t v, input int vi);
    int lat;
    int bad;
    logic [DW-1:0] exp_data;
    if (v.flush_first) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    rd_addr_q.delete();
    rd_cyc_q.delete();
    chk($sformatf("v%0d_req_ready_pre", vi), DW'(req_ready), DW'(1));
    req_valid = 1'b1;
    req_addr  = v.idx;
    flush     = v.flush_with;
    tick();
    req_valid = 1'b0;
    req_addr  = '0;
    flush     = 1'b0;
    lat = 1;
    while (!tri_ready && lat < 40) begin
      flush = (v.flush_during && lat == 3);
      tick();
      lat++;
    end
    flush = 1'b0;
    if (v.exp_err) begin
      exp_data = last_good;
    end else begin
      for (int k = 0; k < TRI_WORDS; k++) begin
        exp_data[k*WORD_W +: WORD_W] = WORD_W'(v.exp_base + k);
      end
    end
    bad = 0;
    for (int k = 0; k < rd_addr_q.size(); k++) begin
      if (rd_addr_q[k] != v.exp_base + k || rd_cyc_q[k] != rd_cyc_q[0] + k) bad++;
    end
    $display("fetch %0d idx=%0d lat=%0d err=%0b reads=%0d", vi, v.idx, lat, tri_err,
             rd_addr_q.size());
    chk($sformatf("v%0d_latency", vi), DW'(lat), DW'(v.exp_lat));
    chk($sformatf("v%0d_tri_err", vi), DW'(tri_err), DW'(v.exp_err));
    chk($sformatf("v%0d_req_ready_done", vi), DW'(req_ready), DW'(1));
    chk($sformatf("v%0d_tri_data", vi), tri_data, exp_data);
    chk($sformatf("v%0d_mem_reads", vi), DW'(rd_addr_q.size()), DW'(v.exp_nrd));
    chk($sformatf("v%0d_mem_seq_bad", vi), DW'(bad), DW'(0));
    if (!v.exp_err) last_good = exp_data;
  endtask

  initial begin
    vec_t v;
    int   ready_cnt;

    //          idx       b2b   ffst  fwith fdur  lat      err   nrd      base
    vecs[0]  = '{12'd3,    1'b0, 1'b0, 1'b0, 1'b0, 12,      1'b0, 9,       27};
    vecs[1]  = '{12'd1024, 1'b0, 1'b0, 1'b0, 1'b0, 1,       1'b1, 0,       0};
    vecs[2]  = '{12'd1023, 1'b0, 1'b0, 1'b0, 1'b0, 12,      1'b0, 9,       9207};
    vecs[3]  = '{12'd0,    1'b0, 1'b0, 1'b0, 1'b0, 12,      1'b0, 9,       0};
    vecs[4]  = '{12'd1,    1'b1, 1'b0, 1'b0, 1'b0, 12,      1'b0, 9,       9};
    vecs[5]  = '{12'd4095, 1'b1, 1'b0, 1'b0, 1'b0, 1,       1'b1, 0,       0};
    vecs[6]  = '{12'd1024, 1'b1, 1'b0, 1'b0, 1'b0, 1,       1'b1, 0,       0};
    vecs[7]  = '{12'd7,    1'b0, 1'b0, 1'b0, 1'b0, 12,      1'b0, 9,       63};
    vecs[8]  = '{12'd7,    1'b0, 1'b0, 1'b0, 1'b0, HIT_LAT, 1'b0, HIT_NRD, 63};
    vecs[9]  = '{12'd7,    1'b0, 1'b1, 1'b0, 1'b0, 12,      1'b0, 9,       63};
    vecs[10] = '{12'd7,    1'b0, 1'b0, 1'b1, 1'b0, 12,      1'b0, 9,       63};
    vecs[11] = '{12'd7,    1'b0, 1'b0, 1'b0, 1'b0, HIT_LAT, 1'b0, HIT_NRD, 63};
    vecs[12] = '{12'd6,    1'b1, 1'b0, 1'b0, 1'b1, 12,      1'b0, 9,       54};
    vecs[13] = '{12'd7,    1'b0, 1'b0, 1'b0, 1'b0, 12,      1'b0, 9,       63};

    // Reset values
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_req_ready", DW'(req_ready), DW'(1));
    chk("rst_mem_en", DW'(mem_en), DW'(0));
    chk("rst_mem_addr", DW'(mem_addr), DW'(0));
    chk("rst_tri_ready", DW'(tri_ready), DW'(0));
    chk("rst_tri_err", DW'(tri_err), DW'(0));
    chk("rst_tri_data", tri_data, '0);

    for (int i = 0; i < NV; i++) begin
      if (!vecs[i].b2b) tick();
      do_fetch(vecs[i], i);
    end

    // Reset in the middle of the idx 5 burst
    tick();
    req_valid = 1'b1;
    req_addr  = 12'd5;
    tick();
    req_valid = 1'b0;
    req_addr  = '0;
    repeat (4) tick();
    chk("abort_mem_en_busy", DW'(mem_en), DW'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("reset during idx=5 fetch");
    chk("abort_req_ready", DW'(req_ready), DW'(1));
    chk("abort_tri_ready", DW'(tri_ready), DW'(0));
    chk("abort_mem_en", DW'(mem_en), DW'(0));
    chk("abort_tri_data", tri_data, '0);
    last_good = '0;
    ready_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (tri_ready) ready_cnt++;
    end
    chk("abort_no_tri_ready", DW'(ready_cnt), DW'(0));
    chk("abort_idle_ready", DW'(req_ready), DW'(1));
    v = '{12'd2, 1'b0, 1'b0, 1'b0, 1'b0, 12, 1'b0, 9, 18};
    do_fetch(v, NV);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
